// File: rtl/row_seq_arbiter.sv
// Row-cycle controller for one bitline/sense-amp group: a round-robin grant across requesters,
// followed by the equalize-off, wordline, sense and precharge phases, each held for a counted interval.
module row_seq_arbiter #(
   parameter int NREQ  = 2,
   parameter int T_EQ  = 2,
   parameter int T_WL  = 3,
   parameter int T_RAS = 8,
   parameter int T_RP  = 4,
   parameter int CW    = 4
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [NREQ-1:0] REQ,
   output logic [NREQ-1:0] GNT,
   output logic            ROW_OPEN,
   output logic [NREQ-1:0] DONE,
   output logic            BUSY,
   output logic            PEQ,
   output logic            PWL,
   output logic            NSA
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {IDLE, EQ_OFF, WL_ON, SENSE, PRECH} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   phase, phase_nxt;
   logic [CW-1:0]   ras, ras_nxt;
   logic [NREQ-1:0] gnt_nxt;
   logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
   logic [NREQ-1:0] pick;
   logic [PW-1:0]   pick_ptr;
   logic [PW-1:0]   idx;
   logic            found;

   // Round-robin search: first set request at or after rr_ptr, wrapping.
   always_comb begin
      pick     = '0;
      pick_ptr = rr_ptr;
      found    = 1'b0;
      idx      = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = PW'((int'(rr_ptr) + i) % NREQ);
         if (!found && REQ[idx]) begin
            found     = 1'b1;
            pick[idx] = 1'b1;
            pick_ptr  = PW'((int'(idx) + 1) % NREQ);
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state  <= IDLE;
         phase  <= '0;
         ras    <= '0;
         GNT    <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_nxt;
         phase  <= phase_nxt;
         ras    <= ras_nxt;
         GNT    <= gnt_nxt;
         rr_ptr <= rr_ptr_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      phase_nxt  = phase;
      ras_nxt    = (ras != '0) ? ras - 1'b1 : ras;
      gnt_nxt    = GNT;
      rr_ptr_nxt = rr_ptr;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt  = EQ_OFF;
               phase_nxt  = CW'(T_EQ - 1);
               gnt_nxt    = pick;
               rr_ptr_nxt = pick_ptr;
            end
         end
         EQ_OFF: begin
            if (phase == '0) begin
               state_nxt = WL_ON;
               phase_nxt = CW'(T_WL - 1);
               ras_nxt   = CW'(T_RAS - 1);
            end else begin
               phase_nxt = phase - 1'b1;
            end
         end
         WL_ON: begin
            if (phase == '0) state_nxt = SENSE;
            else             phase_nxt = phase - 1'b1;
         end
         SENSE: begin
            // The row stays open while the owner still holds its request.
            if (ras == '0 && (REQ & GNT) == '0) begin
               state_nxt = PRECH;
               phase_nxt = CW'(T_RP - 1);
            end
         end
         PRECH: begin
            if (phase == '0) begin
               state_nxt = IDLE;
               gnt_nxt   = '0;
            end else begin
               phase_nxt = phase - 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign PEQ      = (state == IDLE);
   assign PWL      = (state == WL_ON) || (state == SENSE);
   assign NSA      = (state == SENSE);
   assign ROW_OPEN = (state == SENSE);
   assign BUSY     = (state != IDLE);
   assign DONE     = GNT & {NREQ{(state == PRECH) && (phase == '0)}};

endmodule
